// File: rtl/sigma_tile_pkg.sv
// Shared sigma-tile definitions: master identifiers used by the MemSplit32 arbiter.
package sigma_tile_pkg;

  typedef logic [0:0] mid_t;

  localparam mid_t M0 = 1'b0;
  localparam mid_t M1 = 1'b1;

endpackage

// File: rtl/arb_resp_fifo.sv
// In-order FIFO with a combinational head output, used to remember which master
// owns each outstanding read.
module arb_resp_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign dout_o  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

// File: rtl/arb_2m1s.sv
// Two-master / one-slave MemSplit32 arbiter: round-robin grant, zero-latency paths,
// and read responses steered back through an in-order owner FIFO.
module arb_2m1s
  import sigma_tile_pkg::*;
#(
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_i,
  output logic        err_o
);

  mid_t r_prio;
  logic r_err;
  logic w_full, w_empty;
  mid_t w_head;
  logic w_elig0, w_elig1, w_gnt_vld, w_accept, w_push, w_pop;
  mid_t w_gnt;

  // Writes never occupy the FIFO, so only reads are held off when it is full.
  assign w_elig0   = m0_req_i && (m0_we_i || !w_full);
  assign w_elig1   = m1_req_i && (m1_we_i || !w_full);
  assign w_gnt_vld = w_elig0 || w_elig1;
  assign w_gnt     = (w_elig0 && w_elig1) ? r_prio : (w_elig1 ? M1 : M0);
  assign w_accept  = w_gnt_vld && s_ack_i;
  assign w_push    = w_accept && !s_we_o;
  assign w_pop     = s_resp_i && !w_empty;

  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    if (w_gnt_vld) begin
      s_req_o = 1'b1;
      if (w_gnt == M0) begin
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
        m0_ack_o  = s_ack_i;
      end else begin
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
        m1_ack_o  = s_ack_i;
      end
    end
  end

  assign m0_resp_o  = !w_empty && (w_head == M0) && s_resp_i;
  assign m1_resp_o  = !w_empty && (w_head == M1) && s_resp_i;
  assign m0_rdata_o = (!w_empty && (w_head == M0)) ? s_rdata_i : '0;
  assign m1_rdata_o = (!w_empty && (w_head == M1)) ? s_rdata_i : '0;
  assign err_o      = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio <= M0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) r_prio <= ~w_gnt;
      if (s_resp_i && w_empty) r_err <= 1'b1;
    end
  end

  arb_resp_fifo #(
    .WIDTH(1),
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_push),
    .pop_i  (w_pop),
    .din_i  (w_gnt),
    .dout_o (w_head),
    .full_o (w_full),
    .empty_o(w_empty)
  );

endmodule
